// File: rtl/switch_reader.sv
// -----------------------------------------------------------------------------
// switch_reader
//
// Samples WIDTH raw slide switches, synchronises them into clk, debounces each
// bit against a shared tick prescaler and reports every accepted change as:
//   - one-cycle registered edge pulses (sw_rise / sw_fall), and
//   - a valid/ready event record holding the new level and the changed bits.
//
// Parameters
//   WIDTH         number of switch inputs
//   TICK_DIV      clocks per debounce tick (>= 2)
//   STABLE_TICKS  consecutive ticks a bit must disagree with sw_db before the
//                 new level is accepted (>= 1)
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   sw_in      in   raw switch pins (asynchronous to clk)
//   sw_db      out  debounced switch levels
//   sw_rise    out  one-cycle pulse per bit on a debounced 0->1 change
//   sw_fall    out  one-cycle pulse per bit on a debounced 1->0 change
//   evt_valid  out  event record available
//   evt_ready  in   consumer accepts the event
//   evt_level  out  sw_db value right after the change
//   evt_mask   out  bits that changed in this event
//   evt_ovf    out  sticky: an event was dropped while the record was stalled
//   clr_ovf    in   synchronous clear of evt_ovf (a simultaneous drop wins)
// -----------------------------------------------------------------------------
module switch_reader #(
  parameter int WIDTH        = 16,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_level,
  output logic [WIDTH-1:0] evt_mask,
  output logic             evt_ovf,
  input  logic             clr_ovf
);

  // Prescaler counter width (TICK_DIV >= 2 so this is at least 1).
  localparam int TW = $clog2(TICK_DIV);
  // Per-bit debounce counter only has to reach STABLE_TICKS-1.
  localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;

  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_TICKS - 1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;      // sw_sync: the only view of sw_in used below
  logic [TW-1:0]    r_tick_cnt;
  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] r_db;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_evt_valid;
  logic [WIDTH-1:0] r_evt_level;
  logic [WIDTH-1:0] r_evt_mask;
  logic             r_evt_ovf;

  // ---------------------------------------------------------------------------
  // Combinational next-state
  // ---------------------------------------------------------------------------
  logic             w_tick;
  logic [WIDTH-1:0] w_db_next;
  logic [CW-1:0]    w_cnt_next [WIDTH];
  logic [WIDTH-1:0] w_chg;        // bits of sw_db that change at this edge
  logic             w_update;     // any bit changes: an update cycle
  logic             w_drop;       // update arrives while the record is stalled

  assign w_tick = (r_tick_cnt == TICK_MAX);

  // Per-bit debounce. Any cycle where the synchronised input agrees with the
  // debounced level restarts the count, so a bounce back costs a full window.
  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_db_next = r_db;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_next[i] = r_cnt[i];
      if (r_sync2[i] == r_db[i]) begin
        w_cnt_next[i] = '0;
      end else if (w_tick) begin
        if (r_cnt[i] == CNT_MAX) begin
          w_db_next[i]  = r_sync2[i];
          w_cnt_next[i] = '0;
        end else begin
          w_cnt_next[i] = r_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign w_chg    = w_db_next ^ r_db;
  assign w_update = |w_chg;
  assign w_drop   = w_update && r_evt_valid && !evt_ready;

  // ---------------------------------------------------------------------------
  // Synchroniser, prescaler, debounce state and edge pulses
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before this edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_tick_cnt <= '0;
      r_db       <= '0;
      r_rise     <= '0;
      r_fall     <= '0;
      // NOTE: the counter array is a register file, not a RAM; it is reset
      // element by element so reset discards any debounce in progress.
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1    <= sw_in;
      r_sync2    <= r_sync1;
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
      r_db       <= w_db_next;
      // Pulses are registered alongside r_db, so they coincide with the first
      // cycle the new level is visible.
      r_rise     <= w_chg & w_db_next;
      r_fall     <= w_chg & ~w_db_next;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Event record: single-entry valid/ready register. A new update overwrites
  // the record only when it is empty or being accepted this cycle; otherwise
  // the record is held and the update is counted as dropped.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt_valid <= 1'b0;
      r_evt_level <= '0;
      r_evt_mask  <= '0;
    end else if (w_update) begin
      if (!r_evt_valid || evt_ready) begin
        r_evt_valid <= 1'b1;
        r_evt_level <= w_db_next;
        r_evt_mask  <= w_chg;
      end
    end else if (r_evt_valid && evt_ready) begin
      r_evt_valid <= 1'b0;
    end
  end

  // Sticky overflow; a drop in the same cycle as clr_ovf keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt_ovf <= 1'b0;
    end else if (w_drop) begin
      r_evt_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_evt_ovf <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign sw_db     = r_db;
  assign sw_rise   = r_rise;
  assign sw_fall   = r_fall;
  assign evt_valid = r_evt_valid;
  assign evt_level = r_evt_level;
  assign evt_mask  = r_evt_mask;
  assign evt_ovf   = r_evt_ovf;

endmodule

// File: tb/tb_switch_reader.sv
// -----------------------------------------------------------------------------
// tb_switch_reader
//
// Directed bench for switch_reader with TICK_DIV=4, STABLE_TICKS=3, which
// puts the step-to-sw_db latency at 11..14 clock edges. Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_switch_reader;

  localparam int WIDTH        = 16;
  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;
  localparam int LAT_MIN      = 11;
  localparam int LAT_MAX      = 14;
  localparam int WAIT_LIMIT   = 40;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] sw_db;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             evt_valid;
  logic             evt_ready;
  logic [WIDTH-1:0] evt_level;
  logic [WIDTH-1:0] evt_mask;
  logic             evt_ovf;
  logic             clr_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  switch_reader #(
    .WIDTH       (WIDTH),
    .TICK_DIV    (TICK_DIV),
    .STABLE_TICKS(STABLE_TICKS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_in    (sw_in),
    .sw_db    (sw_db),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_level(evt_level),
    .evt_mask (evt_mask),
    .evt_ovf  (evt_ovf),
    .clr_ovf  (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance edge by edge until sw_db changes; n returns the number of edges.
  task automatic wait_db_change(input string tag, output int n);
    logic [WIDTH-1:0] prev;
    bit               seen;
    prev = sw_db;
    seen = 0;
    n    = 0;
    while (!seen && n < WAIT_LIMIT) begin
      step();
      n++;
      if (sw_db !== prev) seen = 1;
    end
    if (!seen) check({tag, "_timeout"}, 32'(n), 32'(WAIT_LIMIT + 1));
  endtask

  task automatic check_latency(input string tag, input int n);
    check(tag, 32'((n >= LAT_MIN) && (n <= LAT_MAX)), 32'd1);
    if (n < LAT_MIN || n > LAT_MAX)
      $display("  %s: latency %0d edges outside %0d..%0d", tag, n, LAT_MIN, LAT_MAX);
  endtask

  initial begin
    int n;
    int rise_cnt;
    int valid_cnt;
    bit db_moved;

    rst_n     = 1'b0;
    sw_in     = '0;
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;
    repeat (3) step();

    // Reset state.
    check("rst_sw_db",     32'(sw_db),     32'h0);
    check("rst_evt_valid", 32'(evt_valid), 32'h0);
    check("rst_evt_ovf",   32'(evt_ovf),   32'h0);
    rst_n = 1'b1;
    repeat (5) step();
    check("idle_sw_db", 32'(sw_db), 32'h0);

    // Clean step 0x0000 -> 0x0001.
    sw_in = 16'h0001;
    wait_db_change("step", n);
    check_latency("step_latency", n);
    check("step_sw_db",      32'(sw_db),     32'h0001);
    check("step_sw_rise",    32'(sw_rise),   32'h0001);
    check("step_sw_fall",    32'(sw_fall),   32'h0000);
    check("step_evt_valid",  32'(evt_valid), 32'h1);
    check("step_evt_level",  32'(evt_level), 32'h0001);
    check("step_evt_mask",   32'(evt_mask),  32'h0001);
    step();
    check("step_rise_end",   32'(sw_rise),   32'h0000);
    check("step_evt_held",   32'(evt_valid), 32'h1);
    evt_ready = 1'b1;
    step();
    check("step_evt_accept", 32'(evt_valid), 32'h0);

    // Bounce on bit 3: toggles every 2 cycles for 40 cycles, then settles at 1.
    db_moved = 0;
    rise_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      sw_in[3] = ((c / 2) % 2 == 0);
      step();
      if (sw_db !== 16'h0001) db_moved = 1;
      if (sw_rise !== '0) rise_cnt++;
    end
    check("bounce_no_change", 32'(db_moved), 32'h0);
    sw_in[3] = 1'b1;
    wait_db_change("bounce", n);
    check("bounce_sw_db",    32'(sw_db),     32'h0009);
    check("bounce_evt_mask", 32'(evt_mask),  32'h0008);
    check("bounce_evt_lvl",  32'(evt_level), 32'h0009);
    valid_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (sw_rise !== '0) rise_cnt++;
      if (evt_valid) valid_cnt++;
      step();
    end
    check("bounce_rise_cnt",  32'(rise_cnt),  32'd1);
    check("bounce_evt_cnt",   32'(valid_cnt), 32'd1);
    check("bounce_ovf",       32'(evt_ovf),   32'h0);

    // Return to 0, then apply 0x8101 in one cycle.
    sw_in = 16'h0000;
    wait_db_change("clear", n);
    check("clear_sw_fall", 32'(sw_fall), 32'h0009);
    repeat (3) step();
    sw_in = 16'h8101;
    wait_db_change("simul", n);
    check_latency("simul_latency", n);
    check("simul_sw_rise",  32'(sw_rise),  32'h8101);
    check("simul_evt_mask", 32'(evt_mask), 32'h8101);
    rise_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (sw_rise !== '0) rise_cnt++;
      step();
    end
    check("simul_one_update", 32'(rise_cnt), 32'd1);
    check("simul_evt_done",   32'(evt_valid), 32'h0);

    // Stall / overflow.
    evt_ready = 1'b0;
    sw_in = 16'h8100;
    wait_db_change("stall_a", n);
    check("stall_a_mask",  32'(evt_mask),  32'h0001);
    check("stall_a_level", 32'(evt_level), 32'h8100);
    check("stall_a_valid", 32'(evt_valid), 32'h1);
    repeat (20) step();
    sw_in = 16'h8102;
    wait_db_change("stall_b", n);
    check("stall_b_sw_db", 32'(sw_db),     32'h8102);
    check("stall_b_mask",  32'(evt_mask),  32'h0001);
    check("stall_b_level", 32'(evt_level), 32'h8100);
    check("stall_b_ovf",   32'(evt_ovf),   32'h1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("stall_clr_ovf", 32'(evt_ovf), 32'h0);
    evt_ready = 1'b1;
    step();
    check("stall_drained", 32'(evt_valid), 32'h0);

    // Falling edge from 0xFFFF.
    sw_in = 16'hFFFF;
    wait_db_change("all_hi", n);
    check("all_hi_sw_db", 32'(sw_db), 32'hFFFF);
    repeat (3) step();
    evt_ready = 1'b0;
    sw_in = 16'h0000;
    wait_db_change("fall", n);
    check("fall_sw_fall",   32'(sw_fall),   32'hFFFF);
    check("fall_evt_level", 32'(evt_level), 32'h0000);
    check("fall_evt_mask",  32'(evt_mask),  32'hFFFF);
    step();
    check("fall_pulse_end", 32'(sw_fall),   32'h0000);

    // Build non-zero state (held record plus overflow), then reset mid-debounce.
    sw_in = 16'h0003;
    wait_db_change("pre_rst", n);
    check("pre_rst_ovf",   32'(evt_ovf),   32'h1);
    sw_in = 16'h0004;
    repeat (8) step();
    rst_n = 1'b0;
    #1;
    check("rst_mid_sw_db",  32'(sw_db),     32'h0);
    check("rst_mid_rise",   32'(sw_rise),   32'h0);
    check("rst_mid_fall",   32'(sw_fall),   32'h0);
    check("rst_mid_valid",  32'(evt_valid), 32'h0);
    check("rst_mid_level",  32'(evt_level), 32'h0);
    check("rst_mid_mask",   32'(evt_mask),  32'h0);
    check("rst_mid_ovf",    32'(evt_ovf),   32'h0);
    step();
    step();
    rst_n = 1'b1;
    wait_db_change("post_rst", n);
    check_latency("post_rst_latency", n);
    check("post_rst_sw_db", 32'(sw_db),   32'h0004);
    check("post_rst_rise",  32'(sw_rise), 32'h0004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
